// File: rtl/dual_port_mem_ctrl.sv
// Two-port (instruction/data) front end to a single-ported word memory with a fixed access latency.
// Define MEM_ARB_RR_EN for round-robin arbitration of simultaneous requests; default is port0 priority.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request; samples and latches the granted one
// ACCESS   | counting LATENCY cycles down; memory updated on exit
// DONE     | done pulse for the granted port; back to IDLE next cycle
module dual_port_mem_ctrl #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_rwe_i,
    input  logic [63:0] mem_addr_i,
    input  logic [7:0]  mem_sel_i,
    input  logic [63:0] mem_data_i,
    output logic [63:0] mem_data_o,
    output logic [1:0]  mem_busy_o,
    output logic [1:0]  mem_done_o
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic             grant;
    logic             op_write;
    logic [IDX_W-1:0] idx;
    logic [3:0]       sel_q;
    logic [31:0]      wdata_q;

    logic [31:0]      mem [MEM_WORDS];

    logic [1:0]       req;
    logic             gnt_nxt;
    logic             wr_nxt;
    logic [31:0]      addr_g;
    logic [29:0]      word_g;
    logic [3:0]       sel_nxt;
    logic [31:0]      wdata_nxt;
    logic             access_end;
    logic             unused_addr_bits;

`ifdef MEM_ARB_RR_EN
    logic             last_grant;
`endif

    always_comb begin
        req = {|mem_rwe_i[3:2], |mem_rwe_i[1:0]};
`ifdef MEM_ARB_RR_EN
        if (&req) begin
            gnt_nxt = ~last_grant;
        end else begin
            gnt_nxt = ~req[0];
        end
`else
        gnt_nxt = ~req[0];
`endif
        addr_g    = gnt_nxt ? mem_addr_i[63:32] : mem_addr_i[31:0];
        wr_nxt    = gnt_nxt ? mem_rwe_i[3]      : mem_rwe_i[1];
        sel_nxt   = gnt_nxt ? mem_sel_i[7:4]    : mem_sel_i[3:0];
        wdata_nxt = gnt_nxt ? mem_data_i[63:32] : mem_data_i[31:0];
        // Word index wraps modulo the store depth; byte offset is dropped.
        word_g    = 30'(addr_g[31:2] % 30'(MEM_WORDS));
    end

    assign unused_addr_bits = ^{addr_g[1:0], word_g[29:IDX_W]};
    assign access_end       = (state == ST_ACCESS) && (cnt == 4'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            grant      <= 1'b0;
            op_write   <= 1'b0;
            idx        <= '0;
            sel_q      <= 4'd0;
            wdata_q    <= 32'd0;
            mem_data_o <= 64'd0;
            mem_busy_o <= 2'b00;
            mem_done_o <= 2'b00;
`ifdef MEM_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            mem_done_o <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state      <= ST_ACCESS;
                        cnt        <= 4'(LATENCY);
                        grant      <= gnt_nxt;
                        op_write   <= wr_nxt;
                        idx        <= word_g[IDX_W-1:0];
                        sel_q      <= sel_nxt;
                        wdata_q    <= wdata_nxt;
                        mem_busy_o <= gnt_nxt ? {1'b1, req[0]} : {req[1], 1'b1};
`ifdef MEM_ARB_RR_EN
                        last_grant <= gnt_nxt;
`endif
                    end else begin
                        mem_busy_o <= 2'b00;
                    end
                end
                ST_ACCESS: begin
                    mem_busy_o <= grant ? {1'b1, req[0]} : {req[1], 1'b1};
                    if (access_end) begin
                        state             <= ST_DONE;
                        cnt               <= 4'd0;
                        mem_done_o[grant] <= 1'b1;
                        if (!op_write) begin
                            if (grant) begin
                                mem_data_o[63:32] <= mem[idx];
                            end else begin
                                mem_data_o[31:0]  <= mem[idx];
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    mem_busy_o <= 2'b00;
                end
                default: begin
                    state      <= ST_IDLE;
                    mem_busy_o <= 2'b00;
                end
            endcase
        end
    end

    // Backing store is never reset; a reset mid-ACCESS forces IDLE, so no write lands.
    always_ff @(posedge clk) begin
        if (access_end && op_write) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_port_mem_ctrl.sv
// Scoreboard bench for dual_port_mem_ctrl: directed scenarios then randomized traffic
// against a word-array reference model; honours MEM_ARB_RR_EN if defined.
module tb_dual_port_mem_ctrl;

    localparam int MEM_WORDS = 1024;
    localparam int LATENCY   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  mem_rwe_i  = 4'd0;
    logic [63:0] mem_addr_i = 64'd0;
    logic [7:0]  mem_sel_i  = 8'd0;
    logic [63:0] mem_data_i = 64'd0;
    logic [63:0] mem_data_o;
    logic [1:0]  mem_busy_o;
    logic [1:0]  mem_done_o;

    dual_port_mem_ctrl #(.MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_rwe_i  (mem_rwe_i),
        .mem_addr_i (mem_addr_i),
        .mem_sel_i  (mem_sel_i),
        .mem_data_i (mem_data_i),
        .mem_data_o (mem_data_o),
        .mem_busy_o (mem_busy_o),
        .mem_done_o (mem_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        bit          rd;
        logic [31:0] data;
        int          exp_cyc;
        logic [1:0]  busy;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [63:0] exp_dout = 64'd0;
    bit          last_g = 1'b1;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t it;
        if (rst && mem_done_o != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {62'd0, mem_done_o}, 64'd0);
            end else begin
                it = sb.pop_front();
                chk("done_port", {62'd0, mem_done_o}, (it.port == 1) ? 64'd2 : 64'd1);
                chk("done_cycle", 64'(cyc), 64'(it.exp_cyc));
                chk("busy_at_done", {62'd0, mem_busy_o}, {62'd0, it.busy});
                if (it.rd) begin
                    if (it.port == 1) exp_dout[63:32] = it.data;
                    else              exp_dout[31:0]  = it.data;
                end
                chk("data_out", mem_data_o, exp_dout);
            end
        end
    end

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % MEM_WORDS);
    endfunction

    // Issue one request pattern at a negedge with the DUT idle; returns at an idle negedge.
    task automatic xfer(input logic [3:0] rwe, input logic [63:0] addr,
                        input logic [7:0] sel, input logic [63:0] data);
        int          order[$];
        int          p, w, t, wi, n;
        bit          wr;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [1:0]  active;
        exp_t        it;
        active = {|rwe[3:2], |rwe[1:0]};
        if (active == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            w = last_g ? 0 : 1;
`else
            w = 0;
`endif
            order.push_back(w);
            order.push_back(1 - w);
        end else if (active[0]) begin
            order.push_back(0);
        end else if (active[1]) begin
            order.push_back(1);
        end else begin
            return;
        end
        t = cyc + 1 + LATENCY;
        for (int k = 0; k < order.size(); k++) begin
            p  = order[k];
            wr = rwe[2*p+1];
            a  = addr[32*p +: 32];
            s  = sel[4*p +: 4];
            d  = data[32*p +: 32];
            wi = word_of(a);
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[wi][8*b +: 8] = d[8*b +: 8];
            end
            it.port    = p;
            it.rd      = !wr;
            it.data    = wr ? 32'd0 : ref_mem[wi];
            it.exp_cyc = t;
            it.busy    = (p == 1) ? {1'b1, (k == 0 && order.size() == 2)}
                                  : {(k == 0 && order.size() == 2), 1'b1};
            sb.push_back(it);
            last_g = p[0];
            t = t + LATENCY + 2;
        end
        mem_rwe_i  = rwe;
        mem_addr_i = addr;
        mem_sel_i  = sel;
        mem_data_i = data;
        n = 0;
        while (active != 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
            for (int q = 0; q < 2; q++) begin
                if (active[q] && mem_done_o[q]) begin
                    active[q] = 1'b0;
                    mem_rwe_i[2*q +: 2] = 2'b00;
                end
            end
        end
        if (active != 2'b00) begin
            chk("done_timeout", {62'd0, active}, 64'd0);
            mem_rwe_i = 4'd0;
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned wi, alias_n, lo;
        wi      = $urandom_range(0, 15);
        alias_n = $urandom_range(0, 3);
        lo      = $urandom_range(0, 3);
        return 32'((wi + alias_n * MEM_WORDS) * 4 + lo);
    endfunction

    initial begin
        logic [3:0] rwe;
        int         kind;

        #2 rst = 1'b0;
        #1;
        chk("reset_busy", {62'd0, mem_busy_o}, 64'd0);
        chk("reset_done", {62'd0, mem_done_o}, 64'd0);
        chk("reset_data", mem_data_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Full write, read back, byte-lane merge.
        xfer(4'b0010, {32'h0, 32'h10}, 8'h0F, {32'h0, 32'hDEADBEEF});
        xfer(4'b0001, {32'h0, 32'h10}, 8'h00, 64'd0);
        xfer(4'b0010, {32'h0, 32'h10}, 8'h05, {32'h0, 32'h11223344});
        xfer(4'b0001, {32'h0, 32'h10}, 8'h00, 64'd0);

        // Index wraps at MEM_WORDS; read back on port1.
        xfer(4'b0010, {32'h0, 32'h1000}, 8'h0F, {32'h0, 32'hCAFEF00D});
        xfer(4'b0100, {32'h0, 32'h0},    8'h00, 64'd0);

        // Simultaneous reads, then a port0 transfer, then another tie.
        xfer(4'b0101, {32'h1000, 32'h10}, 8'h00, 64'd0);
        xfer(4'b0010, {32'h0, 32'h30}, 8'h0F, {32'h0, 32'h0BADF00D});
        xfer(4'b0101, {32'h30, 32'h0}, 8'h00, 64'd0);

        // Reset in the middle of a write must leave the old word intact.
        xfer(4'b0010, {32'h0, 32'h20}, 8'h0F, {32'h0, 32'h12345678});
        mem_rwe_i  = 4'b0010;
        mem_addr_i = {32'h0, 32'h20};
        mem_sel_i  = 8'h0F;
        mem_data_i = {32'h0, 32'h55555555};
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", {62'd0, mem_busy_o}, 64'd0);
        chk("abort_done", {62'd0, mem_done_o}, 64'd0);
        chk("abort_data", mem_data_o, 64'd0);
        mem_rwe_i = 4'd0;
        exp_dout  = 64'd0;
        last_g    = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk);
        xfer(4'b0001, {32'h0, 32'h20}, 8'h00, 64'd0);

        // Both rwe bits set counts as a write.
        xfer(4'b0011, {32'h0, 32'h40}, 8'h0F, {32'h0, 32'hA5A5A5A5});
        xfer(4'b0001, {32'h0, 32'h40}, 8'h00, 64'd0);

        // Randomized traffic over 16 words and their aliases.
        for (int i = 0; i < 16; i++)
            xfer(4'b0010, {32'h0, 32'(i * 4)}, 8'h0F, {32'h0, $urandom()});
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            rwe  = 4'd0;
            if (kind != 1) rwe[1:0] = 2'($urandom_range(1, 3));
            if (kind != 0) rwe[3:2] = 2'($urandom_range(1, 3));
            xfer(rwe, {rand_addr(), rand_addr()}, 8'($urandom()), {$urandom(), $urandom()});
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
